// File: rtl/ods_pkg.sv
// Shared types and constants for the one-hot display scheduler.
package ods_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned CNT_W = 16;

  // Convert a requester index into its one-hot decoder code.
  function automatic logic [N_REQ-1:0] toOnehot(input logic [2:0] idx);
    logic [N_REQ-1:0] code;
    code      = '0;
    code[idx] = 1'b1;
    return code;
  endfunction

endpackage

// File: rtl/onehot_display_scheduler_if.sv
// Request/display bundle between the tile logic and the scheduler.
interface onehot_display_scheduler_if;
  import ods_pkg::*;

  logic [N_REQ-1:0] req_in;
  logic             clr_in;
  logic [N_REQ-1:0] sel_onehot;
  logic [2:0]       grant_idx;
  logic             disp_valid;
  logic [N_REQ-1:0] pending;
  logic             busy;

  modport master (
    output req_in, clr_in,
    input  sel_onehot, grant_idx, disp_valid, pending, busy
  );

  modport slave (
    input  req_in, clr_in,
    output sel_onehot, grant_idx, disp_valid, pending, busy
  );

endinterface

// File: rtl/onehot_display_scheduler_rr_pick8.sv
// Combinational round-robin selector over eight request lines.
module rr_pick8 (
  input  logic [7:0] reqVec,
  input  logic [2:0] lastGrant,
  output logic       found,
  output logic [2:0] idx
);

  logic [2:0] cand;

  // Search upward from lastGrant+1, wrapping at 8; first set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      cand = lastGrant + 3'(k);
      if (!found && reqVec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/onehot_display_scheduler.sv
// Round-robin scheduler feeding one one-hot code at a time to the segment decoder.
module onehot_display_scheduler #(
  parameter int N_REQ        = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  onehot_display_scheduler_if.slave bus
);
  import ods_pkg::*;

  if (N_REQ != 8) begin : gChkNReq
    $fatal(1, "N_REQ must be 8");
  end
  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 65535) begin : gChkDwell
    $fatal(1, "DWELL_CYCLES out of range 1..65535");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES > 65535) begin : gChkBlank
    $fatal(1, "BLANK_CYCLES out of range 0..65535");
  end

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD =
    (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       reqQ;
  logic [2:0]       lastGrant;
  logic [7:0]       rise;
  logic [7:0]       grantMask;
  logic [7:0]       pendingNext;
  logic             pickFound;
  logic [2:0]       pickIdx;

  rr_pick8 uPick (
    .reqVec   (bus.pending),
    .lastGrant(lastGrant),
    .found    (pickFound),
    .idx      (pickIdx)
  );

  // Edge detect and pending update: clear beats set, set beats grant-clear.
  always_comb begin
    rise      = bus.req_in & ~reqQ;
    grantMask = '0;
    if (state == IDLE && pickFound) begin
      grantMask = toOnehot(pickIdx);
    end
    pendingNext = bus.clr_in ? '0 : ((bus.pending & ~grantMask) | rise);
  end

  // Scheduler FSM with dwell/blank counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      reqQ           <= '0;
      lastGrant      <= 3'd7;
      bus.pending    <= '0;
      bus.sel_onehot <= '0;
      bus.grant_idx  <= '0;
      bus.disp_valid <= 1'b0;
      bus.busy       <= 1'b0;
    end else if (ena) begin
      reqQ        <= bus.req_in;
      bus.pending <= pendingNext;
      case (state)
        IDLE: begin
          if (pickFound) begin
            bus.sel_onehot <= toOnehot(pickIdx);
            bus.grant_idx  <= pickIdx;
            lastGrant      <= pickIdx;
            cnt            <= DWELL_LOAD;
            bus.disp_valid <= 1'b1;
            bus.busy       <= 1'b1;
            state          <= SHOW;
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            bus.sel_onehot <= '0;
            bus.disp_valid <= 1'b0;
            if (BLANK_CYCLES > 0) begin
              cnt   <= BLANK_LOAD;
              state <= BLANK;
            end else begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        BLANK: begin
          if (cnt == '0) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_display_scheduler.sv
// Directed self-checking bench for onehot_display_scheduler.
module tb_onehot_display_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  int   errors = 0;
  int   checks = 0;
  int   cycleCnt = 0;

  onehot_display_scheduler_if ifA ();
  onehot_display_scheduler_if ifB ();

  // DWELL=4, BLANK=2: grant-to-grant period 7
  onehot_display_scheduler #(.N_REQ(8), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dutA (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifA.slave)
  );

  // DWELL=1, BLANK=0: grant every other cycle
  onehot_display_scheduler #(.N_REQ(8), .DWELL_CYCLES(1), .BLANK_CYCLES(0)) dutB (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifB.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycleCnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    ena = 1'b1;
    ifA.req_in = '0; ifA.clr_in = 1'b0;
    ifB.req_in = '0; ifB.clr_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Advance until dutA disp_valid rises; bounded, returns sel=0 on timeout.
  task automatic waitGrant(output logic [7:0] sel, output logic [2:0] idx, output int cyc);
    logic prev;
    bit   seen;
    prev = ifA.disp_valid;
    seen = 1'b0;
    sel = '0; idx = '0; cyc = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (ifA.disp_valid && !prev) begin
        seen = 1'b1;
        sel  = ifA.sel_onehot;
        idx  = ifA.grant_idx;
        cyc  = cycleCnt;
      end
      prev = ifA.disp_valid;
    end
  endtask

  logic [7:0] gSel;
  logic [2:0] gIdx;
  int         c1, c2, c3;

  initial begin
    // Reset state
    doReset();
    chk("rst_sel", ifA.sel_onehot, 8'h00);
    chk("rst_idx", ifA.grant_idx, 3'd0);
    chk("rst_valid", ifA.disp_valid, 1'b0);
    chk("rst_pending", ifA.pending, 8'h00);
    chk("rst_busy", ifA.busy, 1'b0);

    // Single request on line 3: dwell 4, blank 2, then idle
    ifA.req_in = 8'h08;
    tick();
    chk("t1_pending", ifA.pending, 8'h08);
    chk("t1_sel_before", ifA.sel_onehot, 8'h00);
    ifA.req_in = 8'h00;
    tick();
    chk("t1_idx", ifA.grant_idx, 3'd3);
    chk("t1_pending_clr", ifA.pending, 8'h00);
    for (int k = 0; k < 4; k++) begin
      chk("t1_dwell_sel", ifA.sel_onehot, 8'h08);
      chk("t1_dwell_valid", ifA.disp_valid, 1'b1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      chk("t1_blank_sel", ifA.sel_onehot, 8'h00);
      chk("t1_blank_busy", ifA.busy, 1'b1);
      tick();
    end
    chk("t1_idle_busy", ifA.busy, 1'b0);

    // Simultaneous rises on 0,5,7: granted in order, period 7
    doReset();
    ifA.req_in = 8'hA1;
    tick();
    chk("t2_pending", ifA.pending, 8'hA1);
    ifA.req_in = 8'h00;
    waitGrant(gSel, gIdx, c1);
    chk("t2_g1_sel", gSel, 8'h01);
    chk("t2_pending_after_g1", ifA.pending, 8'hA0);
    waitGrant(gSel, gIdx, c2);
    chk("t2_g2_sel", gSel, 8'h20);
    chk("t2_g2_idx", gIdx, 3'd5);
    chk("t2_g2_spacing", c2 - c1, 7);
    waitGrant(gSel, gIdx, c3);
    chk("t2_g3_sel", gSel, 8'h80);
    chk("t2_g3_spacing", c3 - c2, 7);

    // Wrap-around: after granting 5, 6 comes before 2
    doReset();
    ifA.req_in = 8'h20;
    tick();
    ifA.req_in = 8'h00;
    tick();
    chk("t3_g5_sel", ifA.sel_onehot, 8'h20);
    ifA.req_in = 8'h44;
    tick();
    chk("t3_pending", ifA.pending, 8'h44);
    ifA.req_in = 8'h00;
    waitGrant(gSel, gIdx, c1);
    chk("t3_first_idx", gIdx, 3'd6);
    chk("t3_first_sel", gSel, 8'h40);
    waitGrant(gSel, gIdx, c2);
    chk("t3_second_idx", gIdx, 3'd2);

    // Re-post of 4 in its own grant cycle stays pending; clr during SHOW
    doReset();
    ifA.req_in = 8'h02;
    tick();                       // E1: pending[1]
    ifA.req_in = 8'h00;
    tick();                       // E2: grant 1
    chk("t4_g1_sel", ifA.sel_onehot, 8'h02);
    ifA.req_in = 8'h10;
    tick();                       // E3: pending[4]
    chk("t4_pending4", ifA.pending, 8'h10);
    ifA.req_in = 8'h00;
    repeat (5) tick();            // E4..E8
    ifA.req_in = 8'h10;
    tick();                       // E9: grant 4 with new edge
    chk("t4_g4_sel", ifA.sel_onehot, 8'h10);
    chk("t4_g4_repending", ifA.pending, 8'h10);
    ifA.req_in = 8'h00;
    waitGrant(gSel, gIdx, c1);
    chk("t4_regrant_idx", gIdx, 3'd4);
    ifA.req_in = 8'h3C;
    tick();
    chk("t4_pending3c", ifA.pending, 8'h3C);
    ifA.req_in = 8'h00;
    ifA.clr_in = 1'b1;
    tick();
    ifA.clr_in = 1'b0;
    chk("t4_clr_pending", ifA.pending, 8'h00);
    chk("t4_clr_sel", ifA.sel_onehot, 8'h10);
    tick();
    chk("t4_last_dwell", ifA.sel_onehot, 8'h10);
    tick();
    chk("t4_blank_sel", ifA.sel_onehot, 8'h00);
    chk("t4_blank_busy", ifA.busy, 1'b1);
    repeat (3) tick();
    chk("t4_no_grant_busy", ifA.busy, 1'b0);
    chk("t4_no_grant_sel", ifA.sel_onehot, 8'h00);

    // BLANK=0, DWELL=1, all pending: walk with one-cycle idle gaps
    doReset();
    ifB.req_in = 8'hFF;
    tick();
    chk("t5_pending", ifB.pending, 8'hFF);
    ifB.req_in = 8'h00;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t5_walk", ifB.sel_onehot, (k % 2 == 0) ? (32'd1 << (k / 2)) : 32'd0);
    end

    // Reset mid-SHOW clears everything at that edge
    doReset();
    ifA.req_in = 8'h08;
    tick();
    ifA.req_in = 8'h00;
    tick();
    ifA.req_in = 8'h40;
    tick();
    ifA.req_in = 8'h00;
    chk("t6_pre_pending", ifA.pending, 8'h40);
    chk("t6_pre_sel", ifA.sel_onehot, 8'h08);
    rst_n = 1'b0;
    tick();
    chk("t6_sel", ifA.sel_onehot, 8'h00);
    chk("t6_idx", ifA.grant_idx, 3'd0);
    chk("t6_valid", ifA.disp_valid, 1'b0);
    chk("t6_pending", ifA.pending, 8'h00);
    chk("t6_busy", ifA.busy, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("t6_after_busy", ifA.busy, 1'b0);

    // ena=0 for 10 cycles mid-SHOW: frozen, dwell total unchanged
    doReset();
    ifA.req_in = 8'h04;
    tick();
    ifA.req_in = 8'h00;
    tick();                       // grant, dwell count 1
    tick();                       // dwell count 2
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) ifA.req_in = 8'h02;
      if (k == 6) ifA.req_in = 8'h00;
      tick();
      chk("t7_frozen_sel", ifA.sel_onehot, 8'h04);
    end
    chk("t7_frozen_pending", ifA.pending, 8'h00);
    ena = 1'b1;
    tick();
    chk("t7_dwell3", ifA.sel_onehot, 8'h04);
    tick();
    chk("t7_dwell4", ifA.sel_onehot, 8'h04);
    tick();
    chk("t7_dwell_end", ifA.sel_onehot, 8'h00);
    chk("t7_pending_end", ifA.pending, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
